// File: rtl/sdram_arbit_pkg.sv
// Shared types for the SDRAM bus arbiter: arbiter state encoding, the idle
// command code and the fixed-priority grant selection.
package sdram_arbit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_ARBIT = 3'b001,
        ST_AREF  = 3'b011,
        ST_WRITE = 3'b010,
        ST_READ  = 3'b110
    } arb_state_e;

    // {cs_n, ras_n, cas_n, we_n} for a no-operation cycle
    localparam logic [3:0] CMD_NOP = 4'b0111;

    // Fixed priority: refresh beats write beats read; no request keeps arbitrating
    function automatic arb_state_e grant_state(input logic aref_req_i,
                                               input logic wr_req_i,
                                               input logic rd_req_i);
        arb_state_e g;
        if (aref_req_i) begin
            g = ST_AREF;
        end else if (wr_req_i) begin
            g = ST_WRITE;
        end else if (rd_req_i) begin
            g = ST_READ;
        end else begin
            g = ST_ARBIT;
        end
        return g;
    endfunction

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter. Holds the bus for the init engine until init completes,
// then grants it to one engine at a time (refresh > write > read), with a
// per-grant watchdog that forces the bus back to arbitration if an engine
// never reports completion. The pin-side command bus is muxed from the state
// register so a reset immediately hands the pins back to the init engine.
import sdram_arbit_pkg::*;

module sdram_arbit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int BANK_W  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              arb_clk,
    input  logic              arb_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BANK_W-1:0] aref_bank,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              arb_err,
    output logic [3:0]        sdram_cmd,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    // Counter only has to reach TIMEOUT-1: the abort fires on the edge that
    // would complete the TIMEOUT-th cycle of the grant.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    arb_state_e       grant_s;
    logic             own_end_s;

    // Pick the engine that would win arbitration this cycle
    always_comb begin
        grant_s = grant_state(aref_req, wr_req, rd_req);
    end

    // Completion pulse of the engine currently holding the bus; others are ignored
    always_comb begin
        own_end_s = 1'b0;
        case (state_r)
            ST_AREF:  own_end_s = aref_end;
            ST_WRITE: own_end_s = wr_end;
            ST_READ:  own_end_s = rd_end;
            default:  own_end_s = 1'b0;
        endcase
    end

    // Arbiter FSM with registered engine enables, watchdog counter and abort pulse
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            arb_err <= 1'b0;
        end else begin
            arb_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (init_end) begin
                        state_r <= ST_ARBIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARBIT: begin
                    state_r <= grant_s;
                    cnt_r   <= {CNT_W{1'b0}};
                    aref_en <= (grant_s == ST_AREF);
                    wr_en   <= (grant_s == ST_WRITE);
                    rd_en   <= (grant_s == ST_READ);
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    if (own_end_s) begin
                        state_r <= ST_ARBIT;
                        aref_en <= 1'b0;
                        wr_en   <= 1'b0;
                        rd_en   <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_ARBIT;
                        aref_en <= 1'b0;
                        wr_en   <= 1'b0;
                        rd_en   <= 1'b0;
                        arb_err <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    aref_en <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Route the owning engine's command bus to the pins; NOP while arbitrating
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = {BANK_W{1'b0}};
        sdram_addr = {ADDR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_bank = aref_bank;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_bank = {BANK_W{1'b0}};
                sdram_addr = {ADDR_W{1'b0}};
            end
        endcase
    end

    // DQ is driven only while the write engine owns the bus and asks to drive
    assign sdram_dq = ((state_r == ST_WRITE) && wr_sdram_en) ? wr_sdram_data
                                                             : {DATA_W{1'bz}};

endmodule
